acumulador_somas: RTL and testbench



---
 rtl/acumulador_somas_pkg.sv | 15 +
 rtl/acumulador_somas_registrador_sinc.sv | 27 ++
 rtl/acumulador_somas.sv | 148 ++++++++++++++
 tb/tb_acumulador_somas.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/acumulador_somas_pkg.sv
// Shared definitions for the adder-result accumulator: state encoding and default widths.
package acumulador_somas_pkg;

  localparam int unsigned LARG_ACC_PADRAO   = 32'd6;
  localparam int unsigned LARG_CONT_PADRAO  = 32'd3;
  localparam int unsigned N_AMOSTRAS_PADRAO = 32'd4;
  localparam int unsigned LARG_SOMA         = 32'd5;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    ACUMULANDO = 2'd1,
    CONCLUIDO  = 2'd2
  } estado_t;

endpackage

// File: rtl/acumulador_somas_registrador_sinc.sv
// Generic register with synchronous active-high clear (priority) and load enable.
module registrador_sinc #(
  parameter int unsigned LARG = 32'd8
) (
  input  logic            clk,
  input  logic            limpa,
  input  logic            carga,
  input  logic [LARG-1:0] d,
  output logic [LARG-1:0] q
);

  logic [LARG-1:0] q_r;

  // Storage: clear wins over load; otherwise hold.
  always_ff @(posedge clk) begin
    if (limpa) begin
      q_r <= '0;
    end else if (carga) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/acumulador_somas.sv
// Accumulates N_AMOSTRAS adder results behind a valid/ready handshake, with sticky
// overflow and a held final total until LIMPA acknowledges the batch.
module acumulador_somas
  import acumulador_somas_pkg::*;
#(
  parameter int unsigned LARG_ACC   = LARG_ACC_PADRAO,
  parameter int unsigned N_AMOSTRAS = N_AMOSTRAS_PADRAO,
  parameter int unsigned LARG_CONT  = LARG_CONT_PADRAO
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [4:0]           SOMA,
  input  logic                 VALIDO,
  output logic                 PRONTO,
  input  logic                 LIMPA,
  output logic [LARG_ACC-1:0]  ACC,
  output logic [LARG_CONT-1:0] CONT,
  output logic                 OVF,
  output logic                 FIM
);

  localparam logic [LARG_CONT-1:0] CONT_FINAL = LARG_CONT'(N_AMOSTRAS);
  localparam logic [LARG_CONT-1:0] CONT_UM    = LARG_CONT'(32'd1);

  estado_t              estado_r;
  logic                 pronto_r;
  logic                 fim_r;
  logic                 ovf_r;
  logic [LARG_ACC-1:0]  acc_q_s;
  logic [LARG_CONT-1:0] cont_q_s;
  logic [LARG_ACC-1:0]  acc_d_s;
  logic [LARG_CONT-1:0] cont_d_s;
  logic [LARG_ACC:0]    soma_total_s;
  logic                 estado_ok_s;
  logic                 aceita_s;
  logic                 limpa_regs_s;

  // Handshake qualification: LIMPA drops a sample presented in the same cycle.
  always_comb begin
    estado_ok_s  = (estado_r == OCIOSO) || (estado_r == ACUMULANDO);
    aceita_s     = VALIDO && pronto_r && !LIMPA && estado_ok_s;
    limpa_regs_s = RST || LIMPA || !(estado_ok_s || (estado_r == CONCLUIDO));
  end

  // Next datapath values; the extra top bit of the sum is the overflow carry.
  always_comb begin
    soma_total_s = {1'b0, acc_q_s} + (LARG_ACC + 1)'(SOMA);
    acc_d_s      = acc_q_s;
    cont_d_s     = cont_q_s;
    case (estado_r)
      OCIOSO: begin
        acc_d_s  = LARG_ACC'(SOMA);
        cont_d_s = CONT_UM;
      end
      ACUMULANDO: begin
        acc_d_s  = soma_total_s[LARG_ACC-1:0];
        cont_d_s = cont_q_s + CONT_UM;
      end
      default: begin
        acc_d_s  = acc_q_s;
        cont_d_s = cont_q_s;
      end
    endcase
  end

  registrador_sinc #(.LARG(LARG_ACC)) u_reg_acc (
    .clk   (CLK),
    .limpa (limpa_regs_s),
    .carga (aceita_s),
    .d     (acc_d_s),
    .q     (acc_q_s)
  );

  registrador_sinc #(.LARG(LARG_CONT)) u_reg_cont (
    .clk   (CLK),
    .limpa (limpa_regs_s),
    .carga (aceita_s),
    .d     (cont_d_s),
    .q     (cont_q_s)
  );

  // Control FSM with registered Moore outputs PRONTO/FIM and the sticky OVF flag.
  always_ff @(posedge CLK) begin
    if (RST || LIMPA) begin
      estado_r <= OCIOSO;
      pronto_r <= 1'b1;
      fim_r    <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (estado_r)
        OCIOSO: begin
          if (aceita_s) begin
            ovf_r <= 1'b0;
            if (cont_d_s == CONT_FINAL) begin
              estado_r <= CONCLUIDO;
              pronto_r <= 1'b0;
              fim_r    <= 1'b1;
            end else begin
              estado_r <= ACUMULANDO;
              pronto_r <= 1'b1;
              fim_r    <= 1'b0;
            end
          end else begin
            estado_r <= OCIOSO;
            pronto_r <= 1'b1;
            fim_r    <= 1'b0;
          end
        end
        ACUMULANDO: begin
          if (aceita_s) begin
            ovf_r <= ovf_r | soma_total_s[LARG_ACC];
            if (cont_d_s == CONT_FINAL) begin
              estado_r <= CONCLUIDO;
              pronto_r <= 1'b0;
              fim_r    <= 1'b1;
            end else begin
              estado_r <= ACUMULANDO;
              pronto_r <= 1'b1;
              fim_r    <= 1'b0;
            end
          end else begin
            estado_r <= ACUMULANDO;
            pronto_r <= 1'b1;
            fim_r    <= 1'b0;
          end
        end
        CONCLUIDO: begin
          estado_r <= CONCLUIDO;
          pronto_r <= 1'b0;
          fim_r    <= 1'b1;
        end
        default: begin
          estado_r <= OCIOSO;
          pronto_r <= 1'b1;
          fim_r    <= 1'b0;
          ovf_r    <= 1'b0;
        end
      endcase
    end
  end

  assign PRONTO = pronto_r;
  assign FIM    = fim_r;
  assign OVF    = ovf_r;
  assign ACC    = acc_q_s;
  assign CONT   = cont_q_s;

endmodule

// File: tb/tb_acumulador_somas.sv
// Self-checking bench: per-cycle comparison against a batch-level model plus directed literal checks.
module tb_acumulador_somas;

  localparam int W = 6;
  localparam int N = 4;
  localparam int C = 3;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [4:0]   SOMA = 5'd0;
  logic         VALIDO = 1'b0;
  logic         LIMPA = 1'b0;
  logic         PRONTO;
  logic [W-1:0] ACC;
  logic [C-1:0] CONT;
  logic         OVF;
  logic         FIM;

  int tests = 0;
  int fails = 0;

  // Model state: the batch total as an integer, how many sums were taken, and flags.
  int m_total = 0;
  int m_count = 0;
  bit m_ovf   = 1'b0;
  bit m_done  = 1'b0;

  acumulador_somas #(.LARG_ACC(W), .N_AMOSTRAS(N), .LARG_CONT(C)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SOMA   (SOMA),
    .VALIDO (VALIDO),
    .PRONTO (PRONTO),
    .LIMPA  (LIMPA),
    .ACC    (ACC),
    .CONT   (CONT),
    .OVF    (OVF),
    .FIM    (FIM)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nome, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
    end
  endtask

  // Model update at each edge, then compare all outputs shortly after.
  always @(posedge CLK) begin
    if (RST || LIMPA) begin
      m_total = 0; m_count = 0; m_ovf = 1'b0; m_done = 1'b0;
    end else if (VALIDO && !m_done) begin
      if (m_count == 0) begin
        m_total = 0;
        m_ovf   = 1'b0;
      end
      m_total = m_total + int'(SOMA);
      if (m_total > (1 << W) - 1) begin
        m_ovf   = 1'b1;
        m_total = m_total % (1 << W);
      end
      m_count++;
      if (m_count == N) m_done = 1'b1;
    end
    #1;
    chk("ACC",    int'(ACC),    m_total);
    chk("CONT",   int'(CONT),   m_count);
    chk("OVF",    int'(OVF),    int'(m_ovf));
    chk("FIM",    int'(FIM),    int'(m_done));
    chk("PRONTO", int'(PRONTO), int'(!m_done));
  end

  task automatic cyc(input bit r, input bit v, input int s, input bit l);
    @(negedge CLK);
    RST = r; VALIDO = v; SOMA = 5'(s); LIMPA = l;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // Reset in the middle of a batch.
    cyc(0, 1, 7, 0);
    cyc(0, 1, 8, 0);
    chk("pre_rst_acc", int'(ACC), 15);
    cyc(1, 1, 9, 0);
    cyc(1, 1, 9, 0);
    chk("rst_acc", int'(ACC), 0);
    chk("rst_cont", int'(CONT), 0);
    chk("rst_pronto", int'(PRONTO), 1);
    chk("rst_fim", int'(FIM), 0);
    cyc(0, 0, 0, 0);

    // Plain batch 5,10,15,20.
    cyc(0, 1, 5, 0);  chk("b1_acc1", int'(ACC), 5);
    cyc(0, 1, 10, 0); chk("b1_acc2", int'(ACC), 15);
    cyc(0, 1, 15, 0); chk("b1_acc3", int'(ACC), 30);
    cyc(0, 1, 20, 0); chk("b1_acc4", int'(ACC), 50);
    chk("b1_cont", int'(CONT), 4);
    chk("b1_fim", int'(FIM), 1);
    chk("b1_pronto", int'(PRONTO), 0);
    chk("b1_ovf", int'(OVF), 0);

    // Samples offered while concluded are not consumed.
    for (int i = 0; i < 3; i++) cyc(0, 1, 7, 0);
    chk("conc_acc", int'(ACC), 50);
    chk("conc_cont", int'(CONT), 4);
    cyc(0, 0, 0, 1);
    chk("limpa_acc", int'(ACC), 0);
    chk("limpa_pronto", int'(PRONTO), 1);
    chk("limpa_fim", int'(FIM), 0);

    // Overflow wrap and sticky flag.
    cyc(0, 1, 31, 0); chk("ov_acc1", int'(ACC), 31);
    cyc(0, 1, 31, 0); chk("ov_acc2", int'(ACC), 62); chk("ov_flag2", int'(OVF), 0);
    cyc(0, 1, 31, 0); chk("ov_acc3", int'(ACC), 29); chk("ov_flag3", int'(OVF), 1);
    cyc(0, 1, 31, 0); chk("ov_acc4", int'(ACC), 60); chk("ov_flag4", int'(OVF), 1);
    chk("ov_fim", int'(FIM), 1);
    cyc(0, 0, 0, 1);
    chk("ov_clr", int'(OVF), 0);

    // Gaps in VALIDO.
    cyc(0, 1, 3, 0);
    cyc(0, 0, 3, 0);
    cyc(0, 0, 3, 0); chk("gap_acc_hold", int'(ACC), 3);
    cyc(0, 1, 3, 0); chk("gap_acc", int'(ACC), 6);
    chk("gap_cont", int'(CONT), 2);
    cyc(0, 0, 0, 1);

    // LIMPA beats a simultaneous sample.
    cyc(0, 1, 9, 0);  chk("lv_acc9", int'(ACC), 9);
    cyc(0, 1, 4, 1);  chk("lv_acc0", int'(ACC), 0); chk("lv_cont0", int'(CONT), 0);
    cyc(0, 1, 4, 0);  chk("lv_acc4", int'(ACC), 4); chk("lv_cont1", int'(CONT), 1);
    cyc(0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(3) != 0),
          int'($urandom_range(31)), ($urandom_range(11) == 0));
    end

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
